// File: rtl/stf_sync_evt.sv
// stf_sync_evt: N-channel async level synchroniser into fastclk with
// optional debounce (macro STF_SYNC_DEBOUNCE_EN), rise/fall pulses and
// a valid/ready change-event port with sticky overflow.
// Ports: fastclk, rst_n (async, active-low), data[N] in;
//   synced/rise/fall[N] out; evt_valid, evt_data[N], evt_chg[N],
//   evt_ovf out; evt_ready in.
module stf_sync_evt #(
  parameter int N          = 2,
  parameter int STAGES     = 2,
  parameter int DEB_CYCLES = 4
) (
  input  logic         fastclk,
  input  logic         rst_n,
  input  logic [N-1:0] data,
  output logic [N-1:0] synced,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         evt_valid,
  input  logic         evt_ready,
  output logic [N-1:0] evt_data,
  output logic [N-1:0] evt_chg,
  output logic         evt_ovf
);

  if (N < 1) begin : g_bad_n
    $error("N must be >= 1");
  end
  if (STAGES < 2) begin : g_bad_stages
    $error("STAGES must be >= 2");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("DEB_CYCLES must be >= 1");
  end

  logic [N-1:0] r_sync [STAGES];
  logic [N-1:0] w_cand;
  logic [N-1:0] w_syn_cur;
  logic [N-1:0] w_syn_nxt;

  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= data;
      for (int s = 1; s < STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_cand = r_sync[STAGES-1];

`ifdef STF_SYNC_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  // The increment that would reach DEB_CYCLES toggles instead, so
  // synced follows cand exactly DEB_CYCLES edges after cand changes.
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  logic [N-1:0]  r_synced;
  logic [CW-1:0] r_cnt     [N];
  logic [CW-1:0] w_cnt_nxt [N];

  always_comb begin
    w_syn_nxt = r_synced;
    for (int i = 0; i < N; i++) begin
      w_cnt_nxt[i] = '0;
      if (w_cand[i] != r_synced[i]) begin
        if (r_cnt[i] == DEB_LAST) begin
          w_syn_nxt[i] = w_cand[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      r_synced <= '0;
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_synced <= w_syn_nxt;
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign w_syn_cur = r_synced;
`else
  // synced is the last chain flop; its next value is the flop before.
  assign w_syn_cur = w_cand;
  assign w_syn_nxt = r_sync[STAGES-2];
`endif

  logic [N-1:0] r_rise;
  logic [N-1:0] r_fall;

  // Pulses are registered from the next synced value so they line up
  // with the first cycle synced shows the new level.
  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_syn_nxt & ~w_syn_cur;
      r_fall <= ~w_syn_nxt & w_syn_cur;
    end
  end

  logic         r_valid;
  logic         r_ovf;
  logic [N-1:0] r_edata;
  logic [N-1:0] r_echg;
  logic [N-1:0] w_chg;
  logic         w_any;
  logic         w_acc;
  logic         w_load;
  logic         w_drop;

  assign w_chg  = r_rise | r_fall;
  assign w_any  = |w_chg;
  assign w_acc  = r_valid & evt_ready;
  assign w_load = w_any & (~r_valid | w_acc);
  assign w_drop = w_any & r_valid & ~w_acc;

  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_edata <= '0;
      r_echg  <= '0;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_edata <= w_syn_cur;
        r_echg  <= w_chg;
      end else if (w_acc) begin
        r_valid <= 1'b0;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_acc) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign synced    = w_syn_cur;
  assign rise      = r_rise;
  assign fall      = r_fall;
  assign evt_valid = r_valid;
  assign evt_data  = r_edata;
  assign evt_chg   = r_echg;
  assign evt_ovf   = r_ovf;

endmodule

// File: tb/tb_stf_sync_evt.sv
// tb_stf_sync_evt: directed bench for stf_sync_evt (N=2, STAGES=2,
// DEB_CYCLES=4); follows STF_SYNC_DEBOUNCE_EN for latency and glitches.
module tb_stf_sync_evt;

`ifdef STF_SYNC_DEBOUNCE_EN
  localparam int DL = 4;
`else
  localparam int DL = 0;
`endif

  logic       fastclk = 1'b0;
  logic       rst_n;
  logic [1:0] data;
  logic [1:0] synced;
  logic [1:0] rise;
  logic [1:0] fall;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_data;
  logic [1:0] evt_chg;
  logic       evt_ovf;

  int checks = 0;
  int errors = 0;

  stf_sync_evt #(
    .N(2),
    .STAGES(2),
    .DEB_CYCLES(4)
  ) dut (
    .fastclk  (fastclk),
    .rst_n    (rst_n),
    .data     (data),
    .synced   (synced),
    .rise     (rise),
    .fall     (fall),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_data (evt_data),
    .evt_chg  (evt_chg),
    .evt_ovf  (evt_ovf)
  );

  always #5 fastclk = ~fastclk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge fastclk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_evt(input string tag,
                         input logic v,
                         input logic [1:0] d,
                         input logic [1:0] c,
                         input logic o);
    chk({tag, ".valid"}, 32'(evt_valid), 32'(v));
    chk({tag, ".data"},  32'(evt_data),  32'(d));
    chk({tag, ".chg"},   32'(evt_chg),   32'(c));
    chk({tag, ".ovf"},   32'(evt_ovf),   32'(o));
  endtask

  initial begin
    rst_n     = 1'b1;
    data      = 2'b11;
    evt_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async.synced", 32'(synced), 32'd0);
    chk_evt("rst_async", 1'b0, 2'b00, 2'b00, 1'b0);
    tick(3);
    chk("rst_hold.synced", 32'(synced), 32'd0);
    chk("rst_hold.rise", 32'(rise), 32'd0);
    chk("rst_hold.fall", 32'(fall), 32'd0);
    chk_evt("rst_hold", 1'b0, 2'b00, 2'b00, 1'b0);

    // release with data=11
    rst_n = 1'b1;
    tick(1);
    chk("rel1.synced", 32'(synced), 32'd0);
    tick(1 + DL);
    chk("rel2.synced", 32'(synced), 32'd3);
    chk("rel2.rise", 32'(rise), 32'd3);
    chk("rel2.valid", 32'(evt_valid), 32'd0);
    tick(1);
    chk("rel3.rise", 32'(rise), 32'd0);
    chk_evt("rel3", 1'b1, 2'b11, 2'b11, 1'b0);
    evt_ready = 1'b1;
    tick(1);
    chk("rel_acc.valid", 32'(evt_valid), 32'd0);

    // settle at 00 with ready high
    data = 2'b00;
    tick(2 + DL);
    chk("fall_all.fall", 32'(fall), 32'd3);
    tick(5);
    chk("idle0.synced", 32'(synced), 32'd0);
    chk("idle0.valid", 32'(evt_valid), 32'd0);

    // single change
    data = 2'b01;
    tick(2 + DL);
    chk("single.synced", 32'(synced), 32'd1);
    chk("single.rise", 32'(rise), 32'd1);
    chk("single.fall", 32'(fall), 32'd0);
    chk("single.valid0", 32'(evt_valid), 32'd0);
    tick(1);
    chk("single.rise_end", 32'(rise), 32'd0);
    chk_evt("single", 1'b1, 2'b01, 2'b01, 1'b0);
    tick(1);
    chk("single.valid_end", 32'(evt_valid), 32'd0);

    // backpressure
    data = 2'b00;
    tick(3 + DL + 3);
    chk("bp_pre.valid", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;
    data = 2'b01;
    tick(3 + DL);
    chk_evt("bp_first", 1'b1, 2'b01, 2'b01, 1'b0);
    tick(7);
    data = 2'b11;
    tick(2 + DL);
    chk("bp_second.rise", 32'(rise), 32'd2);
    chk("bp_second.ovf0", 32'(evt_ovf), 32'd0);
    tick(1);
    chk_evt("bp_held", 1'b1, 2'b01, 2'b01, 1'b1);
    tick(4);
    chk_evt("bp_still", 1'b1, 2'b01, 2'b01, 1'b1);
    evt_ready = 1'b1;
    tick(1);
    chk("bp_acc.valid", 32'(evt_valid), 32'd0);
    chk("bp_acc.ovf", 32'(evt_ovf), 32'd0);
    evt_ready = 1'b0;

    // accept coincident with a new change
    data = 2'b01;
    tick(2 + DL);
    chk("ac.fall1", 32'(fall), 32'd2);
    tick(1);
    chk_evt("ac_first", 1'b1, 2'b01, 2'b10, 1'b0);
    data = 2'b00;
    tick(2 + DL);
    chk("ac.fall0", 32'(fall), 32'd1);
    chk("ac.valid_pend", 32'(evt_valid), 32'd1);
    evt_ready = 1'b1;
    tick(1);
    chk_evt("ac_new", 1'b1, 2'b00, 2'b01, 1'b0);
    evt_ready = 1'b0;

    // build pending event with overflow, then async reset
    data = 2'b01;
    tick(3 + DL);
    chk_evt("pre_rst", 1'b1, 2'b00, 2'b01, 1'b1);
    data = 2'b00;
    tick(3 + DL);
    chk("pre_rst.synced", 32'(synced), 32'd0);
    @(negedge fastclk);
    rst_n = 1'b0;
    #1;
    chk_evt("mid_rst", 1'b0, 2'b00, 2'b00, 1'b0);
    tick(2);
    rst_n = 1'b1;
    for (int k = 0; k < 8 + DL; k++) begin
      tick(1);
      chk("post_rst.valid", 32'(evt_valid), 32'd0);
      chk("post_rst.rise", 32'(rise), 32'd0);
    end
    chk("post_rst.ovf", 32'(evt_ovf), 32'd0);

`ifdef STF_SYNC_DEBOUNCE_EN
    // 3-cycle glitch must be filtered
    data = 2'b10;
    tick(3);
    data = 2'b00;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("glitch.synced", 32'(synced), 32'd0);
      chk("glitch.rise", 32'(rise), 32'd0);
      chk("glitch.valid", 32'(evt_valid), 32'd0);
    end
    // held level appears 2+4 edges after the input
    data = 2'b10;
    tick(5);
    chk("deb5.synced", 32'(synced), 32'd0);
    tick(1);
    chk("deb6.synced", 32'(synced), 32'd2);
    chk("deb6.rise", 32'(rise), 32'd2);
    tick(1);
    chk_evt("deb_evt", 1'b1, 2'b10, 2'b10, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
